// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and funct3 size helpers for the load/store unit.
package lsu_pkg;

  localparam int LANE_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_t;

  // Illegal encodings (011, 11x) all have bit 1 set, so they fall out as word accesses.
  function automatic logic is_word(input logic [2:0] f3);
    return f3[1];
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

  function automatic logic is_byte(input logic [2:0] f3);
    return f3[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory bus of the load/store unit.
interface lsu_if #(
  parameter int ADDR_W = 32
);
  // Handshake: a request transfers on an edge where req_valid && req_ready are both
  // high (and clk_enable is high); rsp_valid is a single-cycle pulse with no backpressure.
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane datapath: load extract/extend and sub-word store merge into a read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] load_word,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic [LANE_W-1:0]   lane_b;
  logic [2*LANE_W-1:0] lane_h;
  logic                sext;

  always_comb begin
    lane_b   = load_word[{offset, 3'b000} +: LANE_W];
    lane_h   = offset[1] ? load_word[31:16] : load_word[15:0];
    sext     = ~funct3[2];
    load_ext = load_word;
    merged   = store_data;
    if (is_byte(funct3)) begin
      load_ext = {{24{sext & lane_b[LANE_W-1]}}, lane_b};
      merged   = old_word;
      merged[{offset, 3'b000} +: LANE_W] = store_data[LANE_W-1:0];
    end else if (is_half(funct3)) begin
      load_ext = {{16{sext & lane_h[2*LANE_W-1]}}, lane_h};
      merged   = old_word;
      if (offset[1]) merged[31:16] = store_data[15:0];
      else           merged[15:0]  = store_data[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory master: one load/store at a time, sub-word stores via read-modify-write.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_enable,
  lsu_if.master      bus,
  output lsu_state_t state_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;
  localparam logic [1:0] RL        = 2'(READ_LATENCY);

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       load_q;
  logic              fault_q;
  logic              misalign_trap;
  logic [ADDR_W-1:0] addr_fix;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_trap = (is_half(bus.req_funct3) && bus.req_addr[0]) ||
                         (is_word(bus.req_funct3) && (bus.req_addr[1:0] != 2'b00));
  assign addr_fix      = bus.req_addr;
`else
  // Without the trap, the offending low bits are dropped and the access goes ahead.
  assign misalign_trap = 1'b0;
  assign addr_fix      = is_word(bus.req_funct3) ? {bus.req_addr[ADDR_W-1:2], 2'b00} :
                         is_half(bus.req_funct3) ? {bus.req_addr[ADDR_W-1:1], 1'b0}  :
                                                   bus.req_addr;
`endif

  lsu_align u_align (
    .funct3     (f3_q),
    .offset     (addr_q[1:0]),
    .load_word  (bus.mem_rdata),
    .old_word   (word_q),
    .store_data (wdata_q),
    .load_ext   (load_ext),
    .merged     (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      load_q  <= '0;
      fault_q <= 1'b0;
    end else if (clk_enable) begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            store_q <= bus.req_store;
            f3_q    <= bus.req_funct3;
            addr_q  <= addr_fix;
            wdata_q <= bus.req_wdata;
            load_q  <= '0;
            fault_q <= misalign_trap;
            if (misalign_trap)                                  state <= S_RESP;
            else if (bus.req_store && is_word(bus.req_funct3))  state <= S_WRITE;
            else begin
              state <= S_RD_WAIT;
              cnt   <= RL;
            end
          end
        end
        S_RD_WAIT: begin
          // Read data is taken on the edge where the count reaches zero.
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            word_q <= bus.mem_rdata;
            load_q <= store_q ? 32'd0 : load_ext;
            state  <= store_q ? S_WRITE : S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = ((state == S_WRITE) || (state == S_RESP)) && clk_enable;
  assign bus.rsp_rdata = (state == S_RESP) ? load_q : 32'd0;
  assign bus.rsp_fault = (state == S_RESP) && fault_q;
  assign bus.mem_addr  = (state != S_IDLE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_we    = (state == S_WRITE) && clk_enable;
  assign bus.mem_wdata = (state == S_WRITE) ? merged : 32'd0;
  assign state_dbg     = lsu_state_t'(state);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases plus random ops vs a word-array model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_enable;
  lsu_state_t state_dbg;

  lsu_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.READ_LATENCY(RL), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_enable (clk_enable),
    .bus        (bus),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // ---------------- memory behaviour and write monitor ----------------
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] rd_q = 32'd0;
  logic        init_done = 1'b0;
  logic        preset_we;
  logic [9:0]  preset_idx;
  logic [31:0] preset_val;
  int          we_total = 0;
  logic [31:0] wr_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E3779B1 ^ 32'hA5A50000;
  endfunction

  assign bus.mem_rdata = rd_q;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (preset_we) mem[preset_idx] <= preset_val;
    else if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    if (bus.mem_we) begin
      we_total <= we_total + 1;
      wr_addr  <= bus.mem_addr;
      wr_data  <= bus.mem_wdata;
    end
    if (clk_enable) rd_q <= mem[bus.mem_addr[11:2]];
  end

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  task automatic model_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] e_rd, output logic e_flt, output int e_lat,
                           output int e_we, output logic [31:0] e_wa, output logic [31:0] e_wd);
    int sz, sh;
    logic [31:0] aa, old, mask;
    sz = size_of(f3);
    e_rd = 0; e_flt = 0; e_we = 0; e_wa = 0; e_wd = 0; e_lat = RL + 1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % sz) != 0) begin
      e_flt = 1; e_lat = 1;
      return;
    end
`endif
    aa   = a - (a % sz);
    sh   = 8 * (aa % 4);
    old  = ref_mem[aa[11:2]];
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1);
    if (st) begin
      e_we = 1;
      e_wa = {aa[31:2], 2'b00};
      e_wd = (old & ~(mask << sh)) | ((wd & mask) << sh);
      ref_mem[aa[11:2]] = e_wd;
      e_lat = (sz == 4) ? 1 : RL + 1;
    end else begin
      e_rd = (old >> sh) & mask;
      if ((f3 == 3'b000 || f3 == 3'b001) && e_rd[8*sz-1]) e_rd = e_rd | ~mask;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic preset(input logic [9:0] idx, input logic [31:0] val);
    preset_idx = idx; preset_val = val; preset_we = 1'b1;
    ref_mem[idx] = val;
    @(posedge clk);
    @(negedge clk);
    preset_we = 1'b0;
    #1;
  endtask

  // Issues one request and follows it to its response; stall_at>0 freezes clk_enable
  // for 4 cycles at that enabled-cycle index. bad counts protocol/stall violations.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int stall_at, output logic [31:0] rd, output logic flt, output int lat,
                        output int nwe, output int bad, output logic tmo);
    int en, stall_left, we_base;
    logic got;
    lsu_state_t s0;
    en = 0; stall_left = (stall_at > 0) ? 4 : 0; got = 0;
    bad = 0; tmo = 0; rd = 0; flt = 0; lat = 0;
    we_base = we_total;
    if (bus.req_ready !== 1'b1) bad++;
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd; clk_enable = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (stall_left > 0 && en + 1 == stall_at) begin
        clk_enable = 1'b0;
        stall_left--;
        #1;
        if (bus.mem_we !== 1'b0 || bus.rsp_valid !== 1'b0) bad++;
        s0 = state_dbg;
        @(posedge clk);
        #1;
        if (state_dbg !== s0) bad++;
      end else begin
        clk_enable = 1'b1;
        en++;
        #1;
        if (bus.req_ready !== 1'b0) bad++;
        if (bus.rsp_valid === 1'b1) begin
          got = 1; lat = en; rd = bus.rsp_rdata; flt = bus.rsp_fault;
        end
      end
    end
    if (!got) tmo = 1;
    @(negedge clk);
    #1;
    if (bus.req_ready !== 1'b1) bad++;
    nwe = we_total - we_base;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
    checks++; if (bus.rsp_fault !== 1'b0) begin errors++; $display("FAIL reset_rsp_fault got=%b exp=0", bus.rsp_fault); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] rd, e_rd, e_wa, e_wd;
    logic flt, tmo, e_flt;
    int lat, nwe, bad, e_lat, e_we;
    preset(10'd64, 32'h8899AABB);
    // LB 0x101
    model_req(0, F3_B, 32'h101, 0, e_rd, e_flt, e_lat, e_we, e_wa, e_wd);
    do_req(0, F3_B, 32'h101, 0, 0, rd, flt, lat, nwe, bad, tmo);
    checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_data got=%h exp=ffffffaa", rd); end
    checks++; if (lat !== 3 || tmo) begin errors++; $display("FAIL lb_latency got=%0d exp=3 tmo=%b", lat, tmo); end
    checks++; if (nwe !== 0 || bad !== 0) begin errors++; $display("FAIL lb_proto writes=%0d bad=%0d exp=0/0", nwe, bad); end
    // LBU 0x101
    model_req(0, F3_BU, 32'h101, 0, e_rd, e_flt, e_lat, e_we, e_wa, e_wd);
    do_req(0, F3_BU, 32'h101, 0, 0, rd, flt, lat, nwe, bad, tmo);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lbu_data got=%h exp=000000aa", rd); end
    // SW 0x12345678 -> 0x7FC
    model_req(1, F3_W, 32'h7FC, 32'h12345678, e_rd, e_flt, e_lat, e_we, e_wa, e_wd);
    do_req(1, F3_W, 32'h7FC, 32'h12345678, 0, rd, flt, lat, nwe, bad, tmo);
    checks++; if (nwe !== 1) begin errors++; $display("FAIL sw_write_count got=%0d exp=1", nwe); end
    checks++; if (wr_addr !== 32'h7FC || wr_data !== 32'h12345678) begin errors++; $display("FAIL sw_write got=%h:%h exp=000007fc:12345678", wr_addr, wr_data); end
    checks++; if (lat !== 1 || rd !== 32'd0 || tmo) begin errors++; $display("FAIL sw_rsp lat=%0d rd=%h exp=1/0", lat, rd); end
    // SB 0x55 -> 0x102
    model_req(1, F3_B, 32'h102, 32'h55, e_rd, e_flt, e_lat, e_we, e_wa, e_wd);
    do_req(1, F3_B, 32'h102, 32'h55, 0, rd, flt, lat, nwe, bad, tmo);
    checks++; if (nwe !== 1 || wr_data !== 32'h8855AABB || wr_addr !== 32'h100) begin errors++; $display("FAIL sb_merge n=%0d got=%h@%h exp=8855aabb@100", nwe, wr_data, wr_addr); end
    checks++; if (lat !== 3 || bad !== 0) begin errors++; $display("FAIL sb_latency got=%0d bad=%0d exp=3/0", lat, bad); end
    // LH 0x102
    model_req(0, F3_H, 32'h102, 0, e_rd, e_flt, e_lat, e_we, e_wa, e_wd);
    do_req(0, F3_H, 32'h102, 0, 0, rd, flt, lat, nwe, bad, tmo);
    checks++; if (rd !== 32'hFFFF8855) begin errors++; $display("FAIL lh_data got=%h exp=ffff8855", rd); end
  endtask

  task automatic test_stall();
    logic [31:0] rd, e_rd, e_wa, e_wd;
    logic flt, tmo, e_flt;
    int lat, nwe, bad, e_lat, e_we;
    preset(10'd80, 32'h11223344);
    model_req(1, F3_B, 32'h141, 32'hA5, e_rd, e_flt, e_lat, e_we, e_wa, e_wd);
    do_req(1, F3_B, 32'h141, 32'hA5, 2, rd, flt, lat, nwe, bad, tmo);
    checks++; if (nwe !== 1 || wr_data !== 32'h1122A544) begin errors++; $display("FAIL stall_rdwait_write n=%0d got=%h exp=1122a544", nwe, wr_data); end
    checks++; if (lat !== 3 || bad !== 0 || tmo) begin errors++; $display("FAIL stall_rdwait_proto lat=%0d bad=%0d exp=3/0", lat, bad); end
    model_req(1, F3_H, 32'h142, 32'h1234BEEF, e_rd, e_flt, e_lat, e_we, e_wa, e_wd);
    do_req(1, F3_H, 32'h142, 32'h1234BEEF, 3, rd, flt, lat, nwe, bad, tmo);
    checks++; if (nwe !== 1 || wr_data !== 32'hBEEFA544) begin errors++; $display("FAIL stall_write_write n=%0d got=%h exp=beefa544", nwe, wr_data); end
    checks++; if (lat !== 3 || bad !== 0 || tmo) begin errors++; $display("FAIL stall_write_proto lat=%0d bad=%0d exp=3/0", lat, bad); end
    model_req(0, F3_W, 32'h140, 0, e_rd, e_flt, e_lat, e_we, e_wa, e_wd);
    do_req(0, F3_W, 32'h140, 0, 1, rd, flt, lat, nwe, bad, tmo);
    checks++; if (rd !== 32'hBEEFA544 || lat !== 3 || bad !== 0) begin errors++; $display("FAIL stall_load got=%h lat=%0d bad=%0d exp=beefa544/3/0", rd, lat, bad); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, e_rd, e_wa, e_wd;
    logic flt, tmo, e_flt;
    int lat, nwe, bad, e_lat, e_we;
    model_req(0, F3_W, 32'h103, 0, e_rd, e_flt, e_lat, e_we, e_wa, e_wd);
    do_req(0, F3_W, 32'h103, 0, 0, rd, flt, lat, nwe, bad, tmo);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (flt !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL misalign_trap flt=%b rd=%h exp=1/0", flt, rd); end
    checks++; if (lat !== 1 || nwe !== 0) begin errors++; $display("FAIL misalign_trap_timing lat=%0d writes=%0d exp=1/0", lat, nwe); end
`else
    checks++; if (flt !== 1'b0 || rd !== 32'h8855AABB) begin errors++; $display("FAIL misalign_clear flt=%b rd=%h exp=0/8855aabb", flt, rd); end
    checks++; if (lat !== 3 || nwe !== 0) begin errors++; $display("FAIL misalign_clear_timing lat=%0d writes=%0d exp=3/0", lat, nwe); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, e_rd, e_wa, e_wd;
    logic flt, tmo, e_flt;
    int lat, nwe, bad, e_lat, e_we, we_base;
    we_base = we_total;
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h200; bus.req_wdata = 32'hDEADBEEF; clk_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_in_write mem_we=%b exp=1", bus.mem_we); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_drop we=%b rsp=%b exp=0/0", bus.mem_we, bus.rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1 || we_total !== we_base) begin errors++; $display("FAIL rstmid_after ready=%b writes=%0d exp=1/0", bus.req_ready, we_total - we_base); end
    model_req(0, F3_W, 32'h200, 0, e_rd, e_flt, e_lat, e_we, e_wa, e_wd);
    do_req(0, F3_W, 32'h200, 0, 0, rd, flt, lat, nwe, bad, tmo);
    checks++; if (rd !== e_rd) begin errors++; $display("FAIL rstmid_mem_intact got=%h exp=%h", rd, e_rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, e_rd, e_wa, e_wd, a, wd, exp_rd;
    logic flt, tmo, e_flt, st;
    logic [2:0] f3;
    logic [2:0] st_f3 [6];
    int lat, nwe, bad, e_lat, e_we, stall;
    st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
    for (int n = 0; n < 80; n++) begin
      st    = 1'($urandom_range(0, 1));
      f3    = st ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      a     = 32'($urandom_range(0, 4095));
      wd    = $urandom;
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      model_req(st, f3, a, wd, e_rd, e_flt, e_lat, e_we, e_wa, e_wd);
      exp_q.push_back(e_rd);
      do_req(st, f3, a, wd, stall, rd, flt, lat, nwe, bad, tmo);
      exp_rd = exp_q.pop_front();
      checks++; if (rd !== exp_rd || flt !== e_flt) begin errors++; $display("FAIL rand_rsp n=%0d st=%b f3=%b a=%h got=%h/%b exp=%h/%b", n, st, f3, a, rd, flt, exp_rd, e_flt); end
      checks++; if (lat !== e_lat || tmo || bad !== 0) begin errors++; $display("FAIL rand_timing n=%0d lat=%0d bad=%0d tmo=%b exp=%0d/0/0", n, lat, bad, tmo, e_lat); end
      checks++; if (nwe !== e_we) begin errors++; $display("FAIL rand_write_count n=%0d got=%0d exp=%0d", n, nwe, e_we); end
      if (e_we == 1) begin
        checks++; if (wr_addr !== e_wa || wr_data !== e_wd) begin errors++; $display("FAIL rand_write n=%0d got=%h@%h exp=%h@%h", n, wr_data, wr_addr, e_wd, e_wa); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clk_enable = 1'b0; preset_we = 1'b0; preset_idx = '0; preset_val = '0;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator-side master for the word-wide data memory, placed between the execute stage and the memory block. It accepts one load or store request at a time and drives word-aligned address, write data and write enable. Sub-word stores are built as read-modify-write, because the memory only writes full words. Load results come back sign- or zero-extended per RV32I funct3.

Parameters:
READ_LATENCY, 2, enabled cycles from mem_addr valid to mem_rdata valid (registered in and out), legal 1..3
ADDR_W, 32, address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_enable  in  1  global advance qualifier; state changes only when high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (IDLE only)
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data; low bytes used for B/H
rsp_valid  out  1  one-enabled-cycle completion pulse (loads and stores)
rsp_rdata  out  32  extended load data; 0 for stores
rsp_fault  out  1  misaligned request (feature-dependent)
mem_addr  out  32  word address to memory; bits [1:0] always 0
mem_wdata  out  32  full word to write
mem_we  out  1  write enable
mem_rdata  in  32  memory read data

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Byte lane mapping: byte offset k occupies bits [8k+7:8k].
- Acceptance: a request is accepted on a clk edge with req_valid && req_ready && clk_enable. The unit captures store, funct3, addr and wdata.
- Enable qualification: every counter and state transition advances only on clk edges with clk_enable=1.
- mem_we gating: mem_we = (state==WRITE) && clk_enable. A stall never repeats a write.
- FSM states: IDLE, RD_WAIT, WRITE, RESP.
  - IDLE: on a load or sub-word store, go to RD_WAIT with the wait counter = READ_LATENCY. On a word store, go to WRITE. On a fault, go to RESP.
  - RD_WAIT: decrement the counter each enabled cycle. At 0, capture mem_rdata, then go to RESP for a load or WRITE for a store.
  - WRITE: mem_wdata holds the merged word. For a B store, only the addressed lane is replaced from req_wdata[7:0]. For an H store, lanes {1,0} or {3,2} are replaced from req_wdata[15:0]. For a W store, req_wdata is passed through. Set rsp_valid=1 this cycle and return to IDLE next enabled edge.
  - RESP: set rsp_valid=1 with rsp_rdata and rsp_fault, then return to IDLE.
- Load extraction:
  - B/H: sign-extend the addressed byte or halfword.
  - BU/HU: zero-extend.
  - W: whole word.
- Addressing: mem_addr = {captured_addr[31:2], 2'b00} from acceptance until return to IDLE.
- Latencies in enabled cycles after acceptance:
  - load response: READ_LATENCY+1
  - word store: mem_we and rsp_valid at cycle 1
  - sub-word store: write at cycle READ_LATENCY+1
- No response backpressure. req_ready=0 outside IDLE. A new request is accepted no earlier than the cycle after rsp_valid.
- Illegal funct3 (011, 11x): treated as W, rsp_fault=0.
- Reset mid-operation: immediate return to IDLE, mem_we drops asynchronously, no response is issued.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: H with addr[0]=1 or W with addr[1:0]!=0 raises rsp_fault=1 with rsp_rdata=0, no memory access and mem_we never asserted. Response arrives 1 enabled cycle after acceptance.
- Undefined: the low address bits that break alignment are cleared (H: addr[0]=0; W: addr[1:0]=0), the access proceeds normally, and rsp_fault is tied to 0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum lsu_state_t
  - LANE_W=8
- One combinational sub-module, lsu_align, holds the lane extract/extend and store merge. The FSM stays in load_store_unit.

Test Plan:
- Memory word 0x100 preset to 0x8899AABB; LB at 0x101, READ_LATENCY=2 -> rsp_valid 3 enabled cycles after acceptance, rsp_rdata=0xFFFFFFAA. LBU at the same address -> 0x000000AA.
- SW 0x12345678 to 0x7FC -> mem_we high exactly 1 cycle with mem_addr=0x7FC and mem_wdata=0x12345678; rsp_valid in the same cycle.
- SB 0x55 to 0x102 over 0x8899AABB -> one read, then one write of 0x8855AABB. LH at 0x102 then returns 0xFFFF8855.
- clk_enable deasserted for 4 cycles during RD_WAIT and WRITE -> state frozen, mem_we=0 during the stall, exactly one write after resume, result unchanged.
- With LSU_MISALIGN_TRAP_EN defined, LW at 0x103 -> rsp_fault=1, rsp_rdata=0, mem_we never set. Without it, LW at 0x103 -> data of word 0x100, fault=0.
- rst_n pulled low in the WRITE state -> mem_we drops immediately, no rsp_valid, req_ready=1 after release.
